// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM access blocks (sdram_write, sdram_read).
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - address field widths and derived bus widths
//   - write-path state enum
//   - page-room helper used when WR_PAGE_CLAMP_EN is defined
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 12;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int LEN_W  = 9;
    localparam int DATA_W = 16;

    typedef logic [3:0] sdram_cmd_t;

    localparam sdram_cmd_t CMD_NOP       = 4'b0111;
    localparam sdram_cmd_t CMD_ACTIVE    = 4'b0011;
    localparam sdram_cmd_t CMD_WRITE     = 4'b0100;
    localparam sdram_cmd_t CMD_BSTOP     = 4'b0110;
    localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;

    typedef enum logic [3:0] {
        WR_IDLE,
        WR_ACTIVE,
        WR_TRCD,
        WR_WRITE,
        WR_DATA,
        WR_BSTOP,
        WR_PRE,
        WR_TRP,
        WR_END
    } wr_state_t;

    // Burst length limited to the words left between the start column and the
    // end of the page; 10-bit arithmetic because a page holds 512 words.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [COL_W-1:0] col);
        logic [COL_W:0] room;
        room = 10'd512 - {1'b0, col};
        if ({1'b0, len} > room) begin
            clamp_len = room[LEN_W-1:0];
        end else begin
            clamp_len = len;
        end
    endfunction

endpackage

// File: rtl/sdram_write_if.sv
// sdram_write_if: bus between the write engine, the FIFO controller / arbiter,
// and the SDRAM command/DQ pins.
//   init_end, wr_en, wr_addr, wr_burst_len, wr_data  : request side (master drives)
//   wr_ack, wr_end                                   : handshake back to FIFO/arbiter
//   write_cmd, write_ba, write_addr                  : SDRAM command/address
//   wr_sdram_en, wr_sdram_data                       : DQ output enable and value
// Modports: slave = sdram_write, master = the surrounding controller / bench.
interface sdram_write_if;
    import sdram_pkg::*;

    logic                init_end;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [LEN_W-1:0]    wr_burst_len;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ack;
    logic                wr_end;
    logic [3:0]          write_cmd;
    logic [BANK_W-1:0]   write_ba;
    logic [ROW_W-1:0]    write_addr;
    logic                wr_sdram_en;
    logic [DATA_W-1:0]   wr_sdram_data;

    modport slave (
        input  init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        output wr_ack, wr_end, write_cmd, write_ba, write_addr,
               wr_sdram_en, wr_sdram_data
    );

    modport master (
        output init_end, wr_en, wr_addr, wr_burst_len, wr_data,
        input  wr_ack, wr_end, write_cmd, write_ba, write_addr,
               wr_sdram_en, wr_sdram_data
    );

endinterface

// File: rtl/sdram_write.sv
// sdram_write: one full-page burst write per arbiter grant.
//   Sequence: ACTIVE, TRCD_CLK NOPs, WRITE + data words, BURST TERMINATE,
//   PRECHARGE (all banks), TRP_CLK NOPs, then a one-cycle wr_end.
// Ports:
//   sys_clk    : system clock
//   sys_rst_n  : asynchronous active-low reset
//   bus        : sdram_write_if.slave (request inputs, wr_ack/wr_end, SDRAM cmd/addr/DQ)
// Parameters:
//   TRCD_CLK   : NOP cycles between ACTIVE and WRITE
//   TRP_CLK    : NOP cycles after PRECHARGE before wr_end
// Build option:
//   WR_PAGE_CLAMP_EN : when defined, the burst is shortened so it never wraps
//                      past the end of the row.
module sdram_write
    import sdram_pkg::*;
#(
    parameter int unsigned TRCD_CLK = 2,
    parameter int unsigned TRP_CLK  = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    sdram_write_if.slave       bus
);

    localparam logic [7:0] TRCD_LAST = 8'(TRCD_CLK - 1);
    localparam logic [7:0] TRP_LAST  = 8'(TRP_CLK - 1);

    wr_state_t         state_q, state_d;
    logic [BANK_W-1:0] bank_q,  bank_d;
    logic [ROW_W-1:0]  row_q,   row_d;
    logic [COL_W-1:0]  col_q,   col_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [7:0]        wait_q,  wait_d;
    logic [LEN_W-1:0]  word_q,  word_d;

    sdram_cmd_t        cmd_q,   cmd_d;
    logic [BANK_W-1:0] ba_q,    ba_d;
    logic [ROW_W-1:0]  addr_q,  addr_d;
    logic              ack_q,   ack_d;
    logic              end_q,   end_d;
    logic              en_q,    en_d;

    logic [LEN_W-1:0]  eff_len;

`ifdef WR_PAGE_CLAMP_EN
    assign eff_len = clamp_len(bus.wr_burst_len, bus.wr_addr[COL_W-1:0]);
`else
    assign eff_len = bus.wr_burst_len;
`endif

    // Next-state logic first; the registered outputs are then decoded from
    // the next state so each command appears in the same cycle as its state.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        len_d   = len_q;
        wait_d  = wait_q;
        word_d  = word_q;

        unique case (state_q)
            WR_IDLE: begin
                if (bus.wr_en && bus.init_end) begin
                    bank_d = bus.wr_addr[ADDR_W-1 -: BANK_W];
                    row_d  = bus.wr_addr[COL_W +: ROW_W];
                    col_d  = bus.wr_addr[COL_W-1:0];
                    len_d  = eff_len;
                    if (eff_len == '0) begin
                        state_d = WR_END;
                    end else begin
                        state_d = WR_ACTIVE;
                    end
                end
            end
            WR_ACTIVE: begin
                wait_d = '0;
                word_d = '0;
                state_d = (TRCD_CLK == 0) ? WR_WRITE : WR_TRCD;
            end
            WR_TRCD: begin
                if (wait_q == TRCD_LAST) begin
                    word_d  = '0;
                    state_d = WR_WRITE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_WRITE, WR_DATA: begin
                if (word_q == len_q - 9'd1) begin
                    state_d = WR_BSTOP;
                end else begin
                    word_d  = word_q + 9'd1;
                    state_d = WR_DATA;
                end
            end
            WR_BSTOP: begin
                state_d = WR_PRE;
            end
            WR_PRE: begin
                wait_d  = '0;
                state_d = (TRP_CLK == 0) ? WR_END : WR_TRP;
            end
            WR_TRP: begin
                if (wait_q == TRP_LAST) begin
                    state_d = WR_END;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WR_END: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase

        cmd_d  = CMD_NOP;
        ba_d   = '1;
        addr_d = '1;
        ack_d  = 1'b0;
        end_d  = 1'b0;
        en_d   = 1'b0;

        unique case (state_d)
            WR_ACTIVE: begin
                cmd_d  = CMD_ACTIVE;
                ba_d   = bank_d;
                addr_d = row_d;
            end
            WR_WRITE: begin
                cmd_d  = CMD_WRITE;
                ba_d   = bank_d;
                addr_d = {3'b000, col_d};
                ack_d  = 1'b1;
                en_d   = 1'b1;
            end
            WR_DATA: begin
                ack_d = 1'b1;
                en_d  = 1'b1;
            end
            WR_BSTOP: begin
                cmd_d = CMD_BSTOP;
            end
            WR_PRE: begin
                // addr[10] high selects precharge of all banks
                cmd_d  = CMD_PRECHARGE;
                ba_d   = bank_d;
                addr_d = 12'h400;
            end
            WR_END: begin
                end_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= WR_IDLE;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            len_q   <= '0;
            wait_q  <= '0;
            word_q  <= '0;
            cmd_q   <= CMD_NOP;
            ba_q    <= '1;
            addr_q  <= '1;
            ack_q   <= 1'b0;
            end_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            col_q   <= col_d;
            len_q   <= len_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            end_q   <= end_d;
            en_q    <= en_d;
        end
    end

    assign bus.write_cmd     = cmd_q;
    assign bus.write_ba      = ba_q;
    assign bus.write_addr    = addr_q;
    assign bus.wr_ack        = ack_q;
    assign bus.wr_end        = end_q;
    assign bus.wr_sdram_en   = en_q;
    // Show-ahead FIFO: the word is already on wr_data in the cycle wr_ack is high.
    assign bus.wr_sdram_data = en_q ? bus.wr_data : '0;

endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: directed bench for sdram_write with a show-ahead FIFO model.
module tb_sdram_write;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_BST = 4'b0110;
    localparam logic [3:0] C_PRE = 4'b0010;

`ifdef WR_PAGE_CLAMP_EN
    localparam int CLAMP_ACKS = 4;
`else
    localparam int CLAMP_ACKS = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int compared   = 0;
    int mismatched = 0;
    int ack_total  = 0;
    int fifo_base  = 0;
    logic [15:0] fifo_mem [0:31];

    sdram_write_if bus();

    sdram_write #(.TRCD_CLK(2), .TRP_CLK(2)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_ack === 1'b1) ack_total <= ack_total + 1;
    end

    assign bus.wr_data = fifo_mem[5'(ack_total - fifo_base)];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo(input logic [15:0] first, input int n);
        fifo_base = ack_total;
        for (int i = 0; i < 32; i++) fifo_mem[i] = (i < n) ? first + 16'(i) : 16'hDEAD;
    endtask

    task automatic start_access(input logic [22:0] addr, input logic [8:0] len);
        bus.wr_addr      = addr;
        bus.wr_burst_len = len;
        bus.init_end     = 1'b1;
        bus.wr_en        = 1'b1;
    endtask

    task automatic wait_end(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (bus.wr_end === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        compared++; if (bus.write_cmd !== C_NOP) begin mismatched++; $display("FAIL reset_cmd: got %b want %b", bus.write_cmd, C_NOP); end
        compared++; if (bus.write_ba !== 2'b11) begin mismatched++; $display("FAIL reset_ba: got %b want 11", bus.write_ba); end
        compared++; if (bus.write_addr !== 12'hFFF) begin mismatched++; $display("FAIL reset_addr: got %h want fff", bus.write_addr); end
        compared++; if (bus.wr_ack !== 1'b0) begin mismatched++; $display("FAIL reset_ack: got %b want 0", bus.wr_ack); end
        compared++; if (bus.wr_end !== 1'b0) begin mismatched++; $display("FAIL reset_end: got %b want 0", bus.wr_end); end
        compared++; if (bus.wr_sdram_en !== 1'b0) begin mismatched++; $display("FAIL reset_en: got %b want 0", bus.wr_sdram_en); end
        compared++; if (bus.wr_sdram_data !== 16'h0) begin mismatched++; $display("FAIL reset_data: got %h want 0000", bus.wr_sdram_data); end
    endtask

    // Basic burst timing plus data integrity: bank 1, row 5, col 5, len 10.
    task automatic test_basic_burst();
        logic [3:0]  exp_cmd;
        logic        exp_ack;
        logic        exp_end;
        logic [15:0] exp_data;
        load_fifo(16'h1000, 10);
        start_access(23'h20_0A05, 9'd10);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 2) begin
                bus.wr_addr      = 23'h7F_FFFF;
                bus.wr_burst_len = 9'd3;
            end
            exp_cmd = (k == 1) ? C_ACT : (k == 4) ? C_WR : (k == 14) ? C_BST : (k == 15) ? C_PRE : C_NOP;
            exp_ack = (k >= 4 && k <= 13);
            exp_end = (k == 18);
            exp_data = exp_ack ? 16'h1000 + 16'(k - 4) : 16'h0000;
            compared++; if (bus.write_cmd !== exp_cmd) begin mismatched++; $display("FAIL burst_cmd c%0d: got %b want %b", k, bus.write_cmd, exp_cmd); end
            compared++; if (bus.wr_ack !== exp_ack) begin mismatched++; $display("FAIL burst_ack c%0d: got %b want %b", k, bus.wr_ack, exp_ack); end
            compared++; if (bus.wr_end !== exp_end) begin mismatched++; $display("FAIL burst_end c%0d: got %b want %b", k, bus.wr_end, exp_end); end
            compared++; if (bus.wr_sdram_en !== exp_ack) begin mismatched++; $display("FAIL burst_en c%0d: got %b want %b", k, bus.wr_sdram_en, exp_ack); end
            compared++; if (bus.wr_sdram_data !== exp_data) begin mismatched++; $display("FAIL burst_data c%0d: got %h want %h", k, bus.wr_sdram_data, exp_data); end
            if (k == 1 || k == 4) begin
                compared++; if (bus.write_ba !== 2'b01) begin mismatched++; $display("FAIL burst_ba c%0d: got %b want 01", k, bus.write_ba); end
                compared++; if (bus.write_addr !== 12'h005) begin mismatched++; $display("FAIL burst_addr c%0d: got %h want 005", k, bus.write_addr); end
            end
            if (k == 15) begin
                compared++; if (bus.write_addr[10] !== 1'b1) begin mismatched++; $display("FAIL burst_pre_a10: got %b want 1", bus.write_addr[10]); end
            end
            if (k == 18) bus.wr_en = 1'b0;
        end
        compared++; if (ack_total - fifo_base !== 10) begin mismatched++; $display("FAIL burst_fifo_drained: got %0d want 10", ack_total - fifo_base); end
        step();
    endtask

    task automatic test_gating();
        bit seen;
        load_fifo(16'h2000, 2);
        bus.init_end     = 1'b0;
        bus.wr_en        = 1'b1;
        bus.wr_addr      = 23'h00_0200;
        bus.wr_burst_len = 9'd2;
        for (int k = 0; k < 20; k++) begin
            step();
            compared++; if (bus.write_cmd !== C_NOP || bus.wr_ack !== 1'b0) begin mismatched++; $display("FAIL gate_idle c%0d: got cmd %b ack %b want %b 0", k, bus.write_cmd, bus.wr_ack, C_NOP); end
        end
        bus.init_end = 1'b1;
        step();
        compared++; if (bus.write_cmd !== C_ACT) begin mismatched++; $display("FAIL gate_active: got %b want %b", bus.write_cmd, C_ACT); end
        wait_end(30, seen);
        compared++; if (!seen) begin mismatched++; $display("FAIL gate_end_timeout: got no wr_end want wr_end"); end
        bus.wr_en = 1'b0;
        step();
    endtask

    task automatic test_zero_length();
        int a0;
        a0 = ack_total;
        start_access(23'h40_0400, 9'd0);
        step();
        compared++; if (bus.wr_end !== 1'b1) begin mismatched++; $display("FAIL zero_end: got %b want 1", bus.wr_end); end
        compared++; if (bus.write_cmd !== C_NOP) begin mismatched++; $display("FAIL zero_cmd1: got %b want %b", bus.write_cmd, C_NOP); end
        bus.wr_en = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            step();
            compared++; if (bus.write_cmd !== C_NOP || bus.wr_end !== 1'b0) begin mismatched++; $display("FAIL zero_idle c%0d: got cmd %b end %b want %b 0", k, bus.write_cmd, bus.wr_end, C_NOP); end
        end
        compared++; if (ack_total !== a0) begin mismatched++; $display("FAIL zero_acks: got %0d want 0", ack_total - a0); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        load_fifo(16'h3000, 4);
        start_access(23'h20_0A05, 9'd2);
        wait_end(30, seen);
        compared++; if (!seen) begin mismatched++; $display("FAIL b2b_first_end: got no wr_end want wr_end"); end
        bus.wr_addr = {2'b10, 12'h123, 9'h000};
        step();
        compared++; if (bus.write_cmd !== C_NOP || bus.wr_end !== 1'b0) begin mismatched++; $display("FAIL b2b_gap: got cmd %b end %b want %b 0", bus.write_cmd, bus.wr_end, C_NOP); end
        step();
        compared++; if (bus.write_cmd !== C_ACT) begin mismatched++; $display("FAIL b2b_active: got %b want %b", bus.write_cmd, C_ACT); end
        compared++; if (bus.write_ba !== 2'b10 || bus.write_addr !== 12'h123) begin mismatched++; $display("FAIL b2b_addr: got ba %b addr %h want 10 123", bus.write_ba, bus.write_addr); end
        wait_end(30, seen);
        compared++; if (!seen) begin mismatched++; $display("FAIL b2b_second_end: got no wr_end want wr_end"); end
        bus.wr_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_fifo(16'h4000, 10);
        start_access(23'h20_0A05, 9'd10);
        for (int k = 1; k <= 7; k++) step();
        compared++; if (bus.wr_ack !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre_ack: got %b want 1", bus.wr_ack); end
        #2;
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        #1;
        compared++; if (bus.write_cmd !== C_NOP || bus.wr_ack !== 1'b0 || bus.wr_end !== 1'b0) begin mismatched++; $display("FAIL rstmid_ctl: got cmd %b ack %b end %b want %b 0 0", bus.write_cmd, bus.wr_ack, bus.wr_end, C_NOP); end
        compared++; if (bus.write_ba !== 2'b11 || bus.write_addr !== 12'hFFF) begin mismatched++; $display("FAIL rstmid_addr: got ba %b addr %h want 11 fff", bus.write_ba, bus.write_addr); end
        compared++; if (bus.wr_sdram_en !== 1'b0 || bus.wr_sdram_data !== 16'h0) begin mismatched++; $display("FAIL rstmid_dq: got en %b data %h want 0 0000", bus.wr_sdram_en, bus.wr_sdram_data); end
        #2;
        rst_n = 1'b1;
        step();
        step();
        compared++; if (bus.write_cmd !== C_NOP || bus.wr_ack !== 1'b0) begin mismatched++; $display("FAIL rstmid_quiet: got cmd %b ack %b want %b 0", bus.write_cmd, bus.wr_ack, C_NOP); end
        load_fifo(16'h4100, 1);
        start_access(23'h20_0A05, 9'd1);
        step();
        compared++; if (bus.write_cmd !== C_ACT) begin mismatched++; $display("FAIL rstmid_idle_accept: got %b want %b", bus.write_cmd, C_ACT); end
        wait_end(30, seen);
        compared++; if (!seen) begin mismatched++; $display("FAIL rstmid_end_timeout: got no wr_end want wr_end"); end
        bus.wr_en = 1'b0;
        step();
    endtask

    task automatic test_clamp();
        bit seen;
        int a0;
        load_fifo(16'h5000, 10);
        a0 = ack_total;
        start_access({2'b00, 12'h010, 9'h1FC}, 9'd10);
        wait_end(60, seen);
        compared++; if (!seen) begin mismatched++; $display("FAIL clamp_end_timeout: got no wr_end want wr_end"); end
        bus.wr_en = 1'b0;
        step();
        compared++; if (ack_total - a0 !== CLAMP_ACKS) begin mismatched++; $display("FAIL clamp_acks: got %0d want %0d", ack_total - a0, CLAMP_ACKS); end
    endtask

    initial begin
        bus.init_end     = 1'b0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_burst_len = '0;
        for (int i = 0; i < 32; i++) fifo_mem[i] = 16'h0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic_burst();
        test_gating();
        test_zero_length();
        test_back_to_back();
        test_reset_mid();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want completion by 100000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- SDRAM-side responder to the FIFO controller's write request: executes one full-page burst write per grant from the command arbiter.
- Drives ACTIVE / WRITE / BURST TERMINATE / PRECHARGE command sequences and asserts wr_ack, which is the read request of the write FIFO.
- Presents FIFO data on the DQ bus and pulses wr_end so the arbiter can release the bus.
- Assumes the SDRAM is initialised in full-page burst mode, CAS latency irrelevant for writes.

Parameters:
TRCD_CLK, 2, NOP cycles between ACTIVE and WRITE
TRP_CLK, 2, NOP cycles after PRECHARGE before wr_end

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
init_end  in  1  SDRAM initialisation complete; wr_en ignored while low
wr_en  in  1  arbiter grant, level; sampled only in IDLE
wr_addr  in  23  burst start: [22:21] bank, [20:9] row, [8:0] column
wr_burst_len  in  9  words per burst, 0..511
wr_data  in  16  write-FIFO q (show-ahead: valid in the same cycle as wr_ack)
wr_ack  out  1  high for exactly one cycle per word transferred
wr_end  out  1  one-cycle pulse when the access is fully complete
write_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
write_ba  out  2  bank address
write_addr  out  12  SDRAM address bus
wr_sdram_en  out  1  DQ output enable
wr_sdram_data  out  16  DQ drive value

Behaviour:
- Reset values:
  - write_cmd = NOP (4'b0111)
  - write_ba = 2'b11, write_addr = 12'hFFF
  - wr_ack, wr_end, wr_sdram_en = 0; wr_sdram_data = 0
  - state = IDLE
- Command encodings:
  - NOP 0111, ACTIVE 0011, WRITE 0100, BSTOP 0110, PRECHARGE 0010
- Address and length latching:
  - wr_addr and wr_burst_len are latched at the edge where IDLE accepts wr_en & init_end (cycle 0).
  - Later changes to either input are ignored until the next access.
- State sequence, cycle numbers relative to acceptance; outputs registered:
  - ACTIVE, cycle 1: cmd ACTIVE, ba = bank, addr = row.
  - TRCD, cycles 2..1+TRCD_CLK: NOP.
  - WRITE, cycle 2+TRCD_CLK: cmd WRITE, addr = {3'b000, column}; first data word in this cycle.
  - DATA: remaining len-1 cycles, cmd NOP. Words are counted with a 9-bit counter, terminal count = len-1.
  - BSTOP: one cycle, cmd BSTOP.
  - PRE: one cycle, cmd PRECHARGE, addr[10] = 1 (all banks).
  - TRP: TRP_CLK cycles of NOP.
  - END: wr_end = 1 for one cycle, then IDLE.
- Data phase (WRITE and DATA cycles):
  - wr_ack = 1, wr_sdram_en = 1, wr_sdram_data = wr_data (combinational pass-through from the show-ahead FIFO).
- wr_burst_len == 0 at acceptance:
  - No SDRAM command is issued and wr_ack is never asserted.
  - wr_end pulses at cycle 1, then IDLE.
- Column wrap: full-page mode wraps the column inside the row; the block does not advance the row (the FIFO controller owns address stepping).
- wr_en is held high by the arbiter until wr_end. wr_en high in the cycle after END starts a new access; there is no mandatory gap.
- wr_en deassertion mid-access is ignored; the access always completes.
- init_end falling mid-access is ignored; it gates acceptance only.
- Reset mid-access: immediate return to reset values. No BSTOP or PRECHARGE is issued; the initialisation block re-precharges.

Optional Feature:
WR_PAGE_CLAMP_EN
- Defined: effective length = min(len, 512 - column), computed at latch with a 10-bit compare. The burst never wraps within the row, and wr_ack count equals the effective length.
- Undefined: effective length = len and wrap is allowed.

Decomposition:
- sdram_pkg:
  - command encodings (NOP, ACTIVE, WRITE, BSTOP, PRECHARGE)
  - state enum
  - address field widths (BANK_W=2, ROW_W=12, COL_W=9)
- sdram_read will share this package.
- Single module; no sub-module warranted. The wait counter is shared across the TRCD and TRP states.

Test Plan:
- Basic burst: wr_addr=23'h20_0A05 (bank 1, row 0x005, col 0x005), len=10, TRCD=TRP=2, wr_en at cycle 0 -> ACTIVE ba=1 addr=0x005 @1; WRITE addr=0x005 @4; wr_ack cycles 4..13 (10 pulses); BSTOP @14; PRECHARGE addr[10]=1 @15; wr_end @18.
- Data integrity: FIFO model with words 0x1000..0x1009, len=10 -> wr_sdram_data sequence 0x1000..0x1009 with wr_sdram_en high; FIFO empty afterwards.
- Gating: wr_en=1 with init_end=0 for 20 cycles -> write_cmd stays NOP, wr_ack=0; raise init_end -> ACTIVE follows one cycle later.
- Zero length: len=0 -> no non-NOP command, wr_ack never high, wr_end @1.
- Back-to-back and reset: second wr_en immediately after wr_end -> ACTIVE one cycle later; reset asserted at cycle 7 of a len=10 burst -> outputs return to reset values asynchronously, state IDLE.
- Clamp: col=0x1FC, len=10 -> with WR_PAGE_CLAMP_EN 4 wr_ack pulses; without the macro, 10 pulses.
